// File: rtl/pd4to16_seq.sv
// Sequential 4-to-16 decoder: accepts {y,z} codes over valid/ready and holds a one-hot word for HOLD cycles.
// Optional accumulated-mask feature is enabled by defining PD16_ACCUM_EN.
module pd4to16_seq #(
    parameter int HOLD = 4,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_y,
    input  logic          in_z,
`ifdef PD16_ACCUM_EN
    input  logic          acc_clr,
    output logic [15:0]   acc_mask,
`endif
    output logic [15:0]   out_w,
    output logic          out_valid,
    output logic [CW-1:0] null_cnt,
    output logic          busy
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [15:0]   out_w_d;
    logic          out_valid_d;
    logic          null_inc;
    logic          accept;
    logic [15:0]   onehot;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready = (state == S_IDLE) || (cnt == '0);
    assign accept   = in_valid && in_ready;
    assign onehot   = 16'h0001 << in_y;
    assign busy     = (state == S_HOLD);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        out_w_d     = out_w;
        out_valid_d = out_valid;
        null_inc    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept && in_z) begin
                    out_w_d     = onehot;
                    out_valid_d = 1'b1;
                    cnt_d       = CW'(HOLD - 1);
                    state_d     = S_HOLD;
                end else if (accept) begin
                    null_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (accept && in_z) begin
                    out_w_d = onehot;
                    cnt_d   = CW'(HOLD - 1);
                end else begin
                    out_w_d     = '0;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    null_inc    = accept;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_w     <= '0;
            out_valid <= 1'b0;
            null_cnt  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            out_w     <= out_w_d;
            out_valid <= out_valid_d;
            if (null_inc && (null_cnt != '1))
                null_cnt <= null_cnt + 1'b1;
        end
    end

`ifdef PD16_ACCUM_EN
    // A clear coinciding with an accept keeps only the newly accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_mask <= '0;
        else if (acc_clr)
            acc_mask <= (accept && in_z) ? onehot : 16'h0000;
        else if (accept && in_z)
            acc_mask <= acc_mask | onehot;
    end
`endif

endmodule

// File: tb/tb_pd4to16_seq.sv
// Randomized + directed bench for pd4to16_seq; two instances (HOLD=4 and HOLD=1) against a remaining-cycles model.
module tb_pd4to16_seq;

    localparam int CW = 8;
    localparam int NULL_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [3:0] in_y;
    logic in_z;

    logic rdy0, rdy1, ov0, ov1, bsy0, bsy1;
    logic [15:0] ow0, ow1;
    logic [CW-1:0] nc0, nc1;
`ifdef PD16_ACCUM_EN
    logic acc_clr;
    logic [15:0] am0, am1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles the current word still has to be shown (0 = idle).
    int          left  [2];
    logic [15:0] word  [2];
    int          nulls [2];
    logic [15:0] acc   [2];

    always #5 clk = ~clk;

    pd4to16_seq #(.HOLD(4), .CW(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_y(in_y), .in_z(in_z),
`ifdef PD16_ACCUM_EN
        .acc_clr(acc_clr), .acc_mask(am0),
`endif
        .out_w(ow0), .out_valid(ov0), .null_cnt(nc0), .busy(bsy0)
    );

    pd4to16_seq #(.HOLD(1), .CW(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_y(in_y), .in_z(in_z),
`ifdef PD16_ACCUM_EN
        .acc_clr(acc_clr), .acc_mask(am1),
`endif
        .out_w(ow1), .out_valid(ov1), .null_cnt(nc1), .busy(bsy1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; word[i] = '0; nulls[i] = 0; acc[i] = '0;
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int  h;
            bit  acpt;
            h    = (i == 0) ? 4 : 1;
            acpt = in_valid && (left[i] <= 1);
`ifdef PD16_ACCUM_EN
            if (acc_clr)
                acc[i] = (acpt && in_z) ? (16'h1 << in_y) : 16'h0;
            else if (acpt && in_z)
                acc[i] = acc[i] | (16'h1 << in_y);
`endif
            if (left[i] > 1) begin
                left[i]--;
            end else if (acpt && in_z) begin
                word[i] = 16'h1 << in_y;
                left[i] = h;
            end else begin
                left[i] = 0;
                word[i] = '0;
                if (acpt && nulls[i] < NULL_MAX) nulls[i]++;
            end
        end
    endtask

    task automatic check_dut(input int i, input logic r, input logic [15:0] w, input logic v,
                             input logic b, input logic [CW-1:0] n);
        string s;
        s = (i == 0) ? "h4" : "h1";
        check({s, "_out_w"},     32'(w), 32'(left[i] > 0 ? word[i] : 16'h0));
        check({s, "_out_valid"}, 32'(v), 32'(left[i] > 0));
        check({s, "_busy"},      32'(b), 32'(left[i] > 0));
        check({s, "_in_ready"},  32'(r), 32'(left[i] <= 1));
        check({s, "_null_cnt"},  32'(n), 32'(nulls[i]));
    endtask

    task automatic check_all();
        check_dut(0, rdy0, ow0, ov0, bsy0, nc0);
        check_dut(1, rdy1, ow1, ov1, bsy1, nc1);
`ifdef PD16_ACCUM_EN
        check("h4_acc_mask", 32'(am0), 32'(acc[0]));
        check("h1_acc_mask", 32'(am1), 32'(acc[1]));
`endif
    endtask

    // Drive at a falling edge, take one rising edge, compare at the next falling edge.
    task automatic cyc(input logic v, input logic [3:0] y, input logic z);
        in_valid = v; in_y = y; in_z = z;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_y = '0; in_z = 1'b0;
`ifdef PD16_ACCUM_EN
        acc_clr = 1'b0;
`endif
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single word, HOLD=4.
        cyc(1'b1, 4'd5, 1'b1);
        check("t1_word", 32'(ow0), 32'h0020);
        check("t1_ready_lo", 32'(rdy0), 32'h0);
        cyc(1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0);
        check("t1_ready_lo3", 32'(rdy0), 32'h0);
        cyc(1'b0, 4'd0, 1'b0);
        check("t1_word4", 32'(ow0), 32'h0020);
        check("t1_ready_hi", 32'(rdy0), 32'h1);
        cyc(1'b0, 4'd0, 1'b0);
        check("t1_cleared", 32'(ow0), 32'h0);
        check("t1_idle", 32'(bsy0), 32'h0);

        // HOLD=1 sweep, one word per cycle.
        for (int y = 15; y >= 0; y--) begin
            cyc(1'b1, 4'(y), 1'b1);
            check("t2_sweep", 32'(ow1), 32'h1 << y);
        end
        cyc(1'b0, 4'd0, 1'b0);

        // Null-code saturation.
        do_reset();
        for (int k = 0; k < 300; k++) cyc(1'b1, 4'($urandom_range(15)), 1'b0);
        check("t3_null_sat", 32'(nc0), 32'd255);
        check("t3_out_zero", 32'(ow0), 32'h0);

        // Request during hold is only taken at cnt==0.
        do_reset();
        cyc(1'b1, 4'd9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 4'd3, 1'b1);
            check("t4_held", 32'(ow0), 32'h0200);
        end
        cyc(1'b1, 4'd3, 1'b1);
        check("t4_new", 32'(ow0), 32'h0008);
        cyc(1'b0, 4'd0, 1'b0);

        // Asynchronous reset in the middle of a hold.
        cyc(1'b1, 4'd7, 1'b1);
        cyc(1'b0, 4'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_out_w", 32'(ow0), 32'h0);
        check("t5_out_valid", 32'(ov0), 32'h0);
        check("t5_busy", 32'(bsy0), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 4'd0, 1'b0);

`ifdef PD16_ACCUM_EN
        cyc(1'b1, 4'd0, 1'b1);
        cyc(1'b1, 4'd1, 1'b1);
        cyc(1'b1, 4'd15, 1'b1);
        check("t6_acc", 32'(am1), 32'h8003);
        acc_clr = 1'b1;
        cyc(1'b1, 4'd2, 1'b1);
        acc_clr = 1'b0;
        check("t6_acc_clr", 32'(am1), 32'h0004);
`endif

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
`ifdef PD16_ACCUM_EN
            acc_clr = ($urandom_range(15) == 0);
`endif
            cyc(($urandom_range(3) != 0), 4'($urandom_range(15)), ($urandom_range(4) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pd4to16_seq.md
# pd4to16_seq

Sequential 4-to-16 decoder: the receiving end of the 16-to-4 priority-encoder interface. Accepts an encoded code `{y[3:0], z}` over a valid/ready handshake and drives a registered one-hot 16-bit word for a programmable number of cycles. Codes with `z=0` (encoder saw no active input) are counted. Sits downstream of `PEn16to4`, re-expanding the encoded request index into a one-hot select for the consumer logic.

## Interface
- `HOLD`, 4, cycles each one-hot word is held on `out_w`; legal range 1..2^CW-1.
- `CW`, 8, width of the hold counter and of `null_cnt`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  code present on `in_y` and `in_z`.
- `in_ready`  out  1  block can accept a code this cycle.
- `in_y`  in  4  encoded index, 0..15.
- `in_z`  in  1  1 = index valid; 0 = no active input.
- `out_w`  out  16  registered one-hot word `1 << y`; all zero when idle.
- `out_valid`  out  1  `out_w` is carrying a decoded word.
- `null_cnt`  out  CW  saturating count of accepted codes with `in_z=0`.
- `busy`  out  1  high in HOLD state.

## Operation
- Accept = `in_valid & in_ready` at a rising edge.
- FSM has two states, IDLE and HOLD. The counter `cnt` is CW bits wide.
- **IDLE**
  - `in_ready=1`.
  - Accept with `in_z=1`: `out_w <= 16'b1 << in_y`, `out_valid <= 1`, `cnt <= HOLD-1`, go to HOLD.
  - Accept with `in_z=0`: `out_w`/`out_valid` stay 0, `null_cnt` increments (saturates at 2^CW-1), stay in IDLE.
- **HOLD**
  - `in_ready = (cnt==0)`.
  - If `cnt!=0`: `cnt` decrements and the word is held.
  - If `cnt==0` and accept with `in_z=1`: load the new word, reload `cnt`, stay in HOLD. This gives back-to-back operation with no bubble.
  - If `cnt==0` and accept with `in_z=0`: `out_w <= 0`, `out_valid <= 0`, `null_cnt` increments, go to IDLE.
  - If `cnt==0` and no accept: `out_w <= 0`, `out_valid <= 0`, go to IDLE.
- `in_y` is ignored when `in_z=0`.
- `in_y`/`in_z` are sampled only on accept. Changes without an accept have no effect.
- `busy = (state==HOLD)`.
- `out_w` is always zero or exactly one-hot, never multi-hot.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - state = IDLE, `cnt`=0, `out_w`=0, `out_valid`=0, `null_cnt`=0, `busy`=0.
  - `in_ready` is combinational from state, so it reads 1 during reset, but no accept is registered while `rst_n=0`.
- Latency: accept at edge k puts the word on `out_w` after edge k.
- Hold time: the word is held for exactly HOLD cycles, and `out_w` clears after edge k+HOLD unless a new code is accepted at that edge.
- HOLD=1: a new code can be accepted every cycle, giving one word per cycle.
- `in_ready` is combinational from registered state only; it never depends on `in_valid`.
- Reset mid-HOLD: outputs clear immediately (async) and the pending word is discarded.

## Configuration
- Macro: `PD16_ACCUM_EN`.
- Defined: adds input `acc_clr` (1 bit) and output `acc_mask` (16 bits, reset 0).
  - On each accept with `in_z=1`, `acc_mask <= acc_mask | (1<<in_y)`.
  - `acc_clr` at an edge gives `acc_mask <= 0`.
  - `acc_clr` in the same cycle as an accept gives `acc_mask <= 1<<in_y`.
- Undefined: both ports and the mask register are absent. All other behaviour is identical.

## Test plan
- Reset, then one accept `y=5, z=1` with HOLD=4 → `out_w=16'h0020` and `out_valid=1` for 4 cycles, `in_ready=0` for the first 3, then `out_w=0`, state IDLE.
- HOLD=1, `in_valid` held high, sweep `y=15..0` with `z=1` → `out_w` steps `16'h8000` down to `16'h0001` one per cycle, no idle cycle between words.
- Accept `z=0` 300 times with CW=8 → `out_w` stays 0 and `null_cnt` saturates at 255.
- `in_valid` high during HOLD with `cnt!=0` and `y=3` → not accepted, held word unchanged. Accepted only when `cnt==0`, after which `out_w=16'h0008`.
- Assert `rst_n=0` mid-HOLD, asynchronously between edges → `out_w=0`, `out_valid=0`, `busy=0` before the next edge.
- With `PD16_ACCUM_EN`: accept `y=0,1,15` → `acc_mask=16'h8003`. Then `acc_clr` together with accept `y=2` → `acc_mask=16'h0004`.
